mask_centroid: RTL and testbench
================================

MASK_CENTROID -- requirements
Module: mask_centroid

Interface
REQ-001 SHALL have parameter H_W, default 11, the hcount width.
REQ-002 SHALL have parameter V_W, default 10, the vcount width.
REQ-003 SHALL have parameter MIN_AREA, default 16, the minimum masked-pixel count for a valid detection.
REQ-004 SHALL have port clk_in, input, 1 bit, the sole clock.
REQ-005 SHALL have port rst_n_in, input, 1 bit; reset is asynchronous and active-low.
REQ-006 SHALL have port pixel_valid_in, input, 1 bit, asserted when the current pixel is in the active area.
REQ-007 SHALL have ports hcount_in (input, H_W bits) and vcount_in (input, V_W bits), the pixel coordinates.
REQ-008 SHALL have port mask_in, input, 1 bit: threshold mask (mask_out_cr / mask_out_cb / mask_out_green) for the current pixel.
REQ-009 SHALL have port frame_done_in, input, 1 bit, a single-cycle pulse on the last pixel of a frame.
REQ-010 SHALL have outputs x_out (H_W bits) and y_out (V_W bits), the centroid coordinates.
REQ-011 SHALL have output area_out, 20 bits, the masked-pixel count of the reported frame.
REQ-012 SHALL have output found_out, 1 bit: area_out >= MIN_AREA.
REQ-013 SHALL have output valid_out, 1 bit, a one-cycle result strobe.
REQ-014 SHALL have output frame_drop_out, 1 bit, a one-cycle strobe when a frame is discarded.

Function
REQ-015 SHALL, on each cycle with pixel_valid_in && mask_in, add hcount_in to sum_x (32 bits), add vcount_in to sum_y (32 bits) and increment count (20 bits).
REQ-016 SHALL treat a pixel coincident with frame_done_in as part of the ending frame.
REQ-017 SHALL, on frame_done_in in state IDLE, latch sum_x, sum_y and count into holding registers and clear the accumulators in the same edge.
REQ-018 SHALL continue accumulating the next frame from the cycle after frame_done_in, so accumulation is double-buffered.
REQ-019 SHALL implement FSM states IDLE, DIV and DONE.
REQ-020 SHALL transition IDLE->DIV on frame_done_in when latched count >= MIN_AREA; otherwise SHALL transition IDLE->DONE with found_out=0.
REQ-021 SHALL, in DIV, compute x = sum_x/count and y = sum_y/count with two parallel restoring dividers, 1 quotient bit/cycle, 32 cycles.
REQ-022 SHALL truncate quotients (floor) and take the low H_W / V_W bits.
REQ-023 SHALL transition DIV->DONE when both dividers finish.
REQ-024 SHALL, in DONE, update outputs and pulse valid_out for one cycle, then return to IDLE.
REQ-025 SHALL assert valid_out exactly 34 cycles after the frame_done_in cycle on the divide path, and 2 cycles after it on the below-MIN_AREA path.
REQ-026 SHALL keep x_out and y_out at their previous values when found_out=0, while area_out is updated.
REQ-027 SHALL, when frame_done_in arrives in DIV or DONE, discard that frame's sums (accumulators still clear), pulse frame_drop_out the next cycle, and leave the in-flight result unaffected.
REQ-028 SHALL hold outputs stable between valid_out strobes.

Reset
REQ-029 SHALL, while rst_n_in=0, asynchronously force the FSM to IDLE and clear accumulators, holding registers and divider state.
REQ-030 SHALL, while rst_n_in=0, drive x_out=0, y_out=0, area_out=0, found_out=0, valid_out=0 and frame_drop_out=0.
REQ-031 SHALL, on reset mid-DIV, abort the division and produce no valid_out after release.
REQ-032 SHALL begin accumulation after reset release only at the next frame_done_in boundary, so the first partial frame is discarded and no valid_out is generated for it.

Configuration
REQ-033 SHALL, with MASK_CENTROID_BBOX_EN defined, additionally track per-frame min/max of hcount_in and vcount_in over masked pixels and output bbox_x0_out, bbox_y0_out, bbox_x1_out and bbox_y1_out, latched at DONE with the same timing as x_out.
REQ-034 SHALL reset the bounding-box min trackers to all-ones and the max trackers to 0, and the bbox outputs to 0.
REQ-035 SHALL, without MASK_CENTROID_BBOX_EN, have no bbox ports and no bbox logic.

Structure
REQ-036 SHALL place the FSM state enum, SUM_W=32 and CNT_W=20 in shared package vision_pkg.
REQ-037 SHALL implement the divider as sub-module seq_divider (start/busy/done handshake, SUM_W-bit dividend, CNT_W-bit divisor), instantiated twice.

Verification
REQ-038 SHALL verify: masked 4x4 block at x 100..103, y 50..53 -> valid_out at +34 cycles with x_out=101, y_out=51, area_out=16, found_out=1; with BBOX_EN, bbox 100,50,103,53.
REQ-039 SHALL verify: frame with no masked pixels -> valid_out at +2 cycles, found_out=0, area_out=0, x_out/y_out unchanged from the prior result.
REQ-040 SHALL verify: second frame_done_in 10 cycles after the first -> frame_drop_out pulse at +11, first result unchanged and delivered at +34.
REQ-041 SHALL verify: masked pixel at (200,100) coincident with frame_done_in -> counted in the ending frame; the next frame starts at area 0.
REQ-042 SHALL verify: rst_n_in pulsed low at DIV cycle 15 -> all outputs 0 immediately and no valid_out after release.
REQ-043 SHALL verify: 15 masked pixels -> found_out=0 at +2; 16 masked pixels -> found_out=1 at +34.

Source files
------------

// File: rtl/vision_pkg.sv
// Shared types and widths for the vision pipeline blocks.
package vision_pkg;

  localparam int unsigned SUM_W = 32;  // coordinate accumulator width
  localparam int unsigned CNT_W = 20;  // masked-pixel counter width

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StDone
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: SUM_W-bit dividend by CNT_W-bit divisor, one quotient bit per cycle.
// start loads the operands; busy stays high for SUM_W cycles; done is high during the
// final iteration, so the quotient is complete from the following cycle.
module seq_divider
  import vision_pkg::*;
#(
  parameter int unsigned QuoW = SUM_W
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start,
  input  logic [SUM_W-1:0] dividend,
  input  logic [CNT_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [QuoW-1:0]  quotient
);

  localparam int unsigned StepW = $clog2(SUM_W);
  localparam logic [StepW-1:0] LastStep = StepW'(SUM_W - 1);

  logic [CNT_W:0]     rem_q, rem_d;
  logic [SUM_W-1:0]   quo_q, quo_d;
  logic [CNT_W-1:0]   dvs_q;
  logic [StepW-1:0]   step_q;
  logic               busy_q;
  logic [CNT_W:0]     rem_shift;

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    rem_shift = {rem_q[CNT_W-1:0], quo_q[SUM_W-1]};
    rem_d     = rem_shift;
    quo_d     = {quo_q[SUM_W-2:0], 1'b0};
    if (rem_shift >= {1'b0, dvs_q}) begin
      rem_d    = rem_shift - {1'b0, dvs_q};
      quo_d[0] = 1'b1;
    end
  end

  // Operand load on start, then iterate until the last step retires.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      step_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      step_q <= step_q + 1'b1;
      if (step_q == LastStep) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (step_q == LastStep);
  assign quotient = quo_q[QuoW-1:0];

endmodule

// File: rtl/mask_centroid.sv
// Centroid of a thresholded mask over one video frame.
// Sums masked coordinates per frame (double-buffered), divides by the pixel count and
// reports x/y/area with a one-cycle valid strobe. Frames ending while a result is still
// in flight are dropped. Define MASK_CENTROID_BBOX_EN to add bounding-box outputs.
module mask_centroid
  import vision_pkg::*;
#(
  parameter int unsigned H_W      = 11,
  parameter int unsigned V_W      = 10,
  parameter int unsigned MIN_AREA = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             pixel_valid_in,
  input  logic [H_W-1:0]   hcount_in,
  input  logic [V_W-1:0]   vcount_in,
  input  logic             mask_in,
  input  logic             frame_done_in,
  output logic [H_W-1:0]   x_out,
  output logic [V_W-1:0]   y_out,
  output logic [CNT_W-1:0] area_out,
  output logic             found_out,
  output logic             valid_out,
  output logic             frame_drop_out
`ifdef MASK_CENTROID_BBOX_EN
  ,
  output logic [H_W-1:0]   bbox_x0_out,
  output logic [V_W-1:0]   bbox_y0_out,
  output logic [H_W-1:0]   bbox_x1_out,
  output logic [V_W-1:0]   bbox_y1_out
`endif
);

  localparam logic [CNT_W-1:0] MinArea = CNT_W'(MIN_AREA);

  state_t           state_q, state_d;
  logic             armed_q;
  logic [SUM_W-1:0] sum_x_q, sum_y_q, sum_x_inc, sum_y_inc;
  logic [CNT_W-1:0] count_q, count_inc, hold_count_q;
  logic             hit, frame_latch, inc_found, hold_found, div_start;
  logic             drop_q;
  logic             x_busy, x_done, y_busy, y_done, div_fin;
  logic [H_W-1:0]   x_quo, x_q;
  logic [V_W-1:0]   y_quo, y_q;
  logic [CNT_W-1:0] area_q;
  logic             found_q, valid_q;

  // Accumulator next values including the current pixel, so a pixel coincident with
  // frame_done_in lands in the ending frame.
  always_comb begin
    hit         = armed_q & pixel_valid_in & mask_in;
    sum_x_inc   = sum_x_q + (hit ? SUM_W'(hcount_in) : '0);
    sum_y_inc   = sum_y_q + (hit ? SUM_W'(vcount_in) : '0);
    count_inc   = count_q + {{(CNT_W - 1){1'b0}}, hit};
    frame_latch = frame_done_in & armed_q & (state_q == StIdle);
    inc_found   = count_inc >= MinArea;
    hold_found  = hold_count_q >= MinArea;
  end

  // Accumulators clear on every frame boundary; armed_q discards the partial first frame.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      armed_q      <= 1'b0;
      sum_x_q      <= '0;
      sum_y_q      <= '0;
      count_q      <= '0;
      hold_count_q <= '0;
      drop_q       <= 1'b0;
    end else begin
      drop_q <= frame_done_in & armed_q & (state_q != StIdle);
      if (frame_done_in) begin
        armed_q <= 1'b1;
        sum_x_q <= '0;
        sum_y_q <= '0;
        count_q <= '0;
        if (frame_latch) begin
          hold_count_q <= count_inc;
        end
      end else begin
        sum_x_q <= sum_x_inc;
        sum_y_q <= sum_y_inc;
        count_q <= count_inc;
      end
    end
  end

  // The dividers capture the frame sums directly as their held dividends.
  seq_divider #(
    .QuoW(H_W)
  ) u_div_x (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .start    (div_start),
    .dividend (sum_x_inc),
    .divisor  (count_inc),
    .busy     (x_busy),
    .done     (x_done),
    .quotient (x_quo)
  );

  seq_divider #(
    .QuoW(V_W)
  ) u_div_y (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .start    (div_start),
    .dividend (sum_y_inc),
    .divisor  (count_inc),
    .busy     (y_busy),
    .done     (y_done),
    .quotient (y_quo)
  );

  // A divider has finished when it is on its last step or already idle.
  assign div_fin = (x_done | ~x_busy) & (y_done | ~y_busy);

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and divider start.
  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_latch) begin
          if (inc_found) begin
            state_d   = StDiv;
            div_start = 1'b1;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDiv:   if (div_fin) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Result registers update only on leaving DONE; x/y keep the last detection.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      x_q     <= '0;
      y_q     <= '0;
      area_q  <= '0;
      found_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= (state_q == StDone);
      if (state_q == StDone) begin
        area_q  <= hold_count_q;
        found_q <= hold_found;
        if (hold_found) begin
          x_q <= x_quo;
          y_q <= y_quo;
        end
      end
    end
  end

  assign x_out          = x_q;
  assign y_out          = y_q;
  assign area_out       = area_q;
  assign found_out      = found_q;
  assign valid_out      = valid_q;
  assign frame_drop_out = drop_q;

`ifdef MASK_CENTROID_BBOX_EN
  logic [H_W-1:0] trk_x0_q, trk_x1_q, hld_x0_q, hld_x1_q, out_x0_q, out_x1_q;
  logic [V_W-1:0] trk_y0_q, trk_y1_q, hld_y0_q, hld_y1_q, out_y0_q, out_y1_q;
  logic [H_W-1:0] trk_x0_inc, trk_x1_inc;
  logic [V_W-1:0] trk_y0_inc, trk_y1_inc;

  // Min/max trackers including the current pixel.
  always_comb begin
    trk_x0_inc = (hit && hcount_in < trk_x0_q) ? hcount_in : trk_x0_q;
    trk_x1_inc = (hit && hcount_in > trk_x1_q) ? hcount_in : trk_x1_q;
    trk_y0_inc = (hit && vcount_in < trk_y0_q) ? vcount_in : trk_y0_q;
    trk_y1_inc = (hit && vcount_in > trk_y1_q) ? vcount_in : trk_y1_q;
  end

  // Bounding box tracks, holds and publishes with the same cadence as the centroid.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      trk_x0_q <= '1;
      trk_y0_q <= '1;
      trk_x1_q <= '0;
      trk_y1_q <= '0;
      hld_x0_q <= '1;
      hld_y0_q <= '1;
      hld_x1_q <= '0;
      hld_y1_q <= '0;
      out_x0_q <= '0;
      out_y0_q <= '0;
      out_x1_q <= '0;
      out_y1_q <= '0;
    end else begin
      if (frame_done_in) begin
        trk_x0_q <= '1;
        trk_y0_q <= '1;
        trk_x1_q <= '0;
        trk_y1_q <= '0;
        if (frame_latch) begin
          hld_x0_q <= trk_x0_inc;
          hld_y0_q <= trk_y0_inc;
          hld_x1_q <= trk_x1_inc;
          hld_y1_q <= trk_y1_inc;
        end
      end else begin
        trk_x0_q <= trk_x0_inc;
        trk_y0_q <= trk_y0_inc;
        trk_x1_q <= trk_x1_inc;
        trk_y1_q <= trk_y1_inc;
      end
      if (state_q == StDone && hold_found) begin
        out_x0_q <= hld_x0_q;
        out_y0_q <= hld_y0_q;
        out_x1_q <= hld_x1_q;
        out_y1_q <= hld_y1_q;
      end
    end
  end

  assign bbox_x0_out = out_x0_q;
  assign bbox_y0_out = out_y0_q;
  assign bbox_x1_out = out_x1_q;
  assign bbox_y1_out = out_y1_q;
`endif

endmodule

// File: tb/tb_mask_centroid.sv
// Directed self-checking bench for mask_centroid (default parameters).
module tb_mask_centroid;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        pixel_valid_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        mask_in;
  logic        frame_done_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic [19:0] area_out;
  logic        found_out;
  logic        valid_out;
  logic        frame_drop_out;
`ifdef MASK_CENTROID_BBOX_EN
  logic [10:0] bbox_x0_out, bbox_x1_out;
  logic [9:0]  bbox_y0_out, bbox_y1_out;
`endif

  int checks = 0;
  int errors = 0;

  mask_centroid dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .pixel_valid_in (pixel_valid_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .mask_in        (mask_in),
    .frame_done_in  (frame_done_in),
    .x_out          (x_out),
    .y_out          (y_out),
    .area_out       (area_out),
    .found_out      (found_out),
    .valid_out      (valid_out),
    .frame_drop_out (frame_drop_out)
`ifdef MASK_CENTROID_BBOX_EN
    ,
    .bbox_x0_out    (bbox_x0_out),
    .bbox_y0_out    (bbox_y0_out),
    .bbox_x1_out    (bbox_x1_out),
    .bbox_y1_out    (bbox_y1_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    pixel_valid_in = 1'b0;
    mask_in        = 1'b0;
    frame_done_in  = 1'b0;
    hcount_in      = '0;
    vcount_in      = '0;
  endtask

  task automatic px(input int x, input int y, input logic v, input logic m);
    pixel_valid_in = v;
    mask_in        = m;
    hcount_in      = 11'(x);
    vcount_in      = 10'(y);
    tick();
    idle();
  endtask

  // Masked block, interleaved with an unmasked pixel and a masked pixel outside the active area.
  task automatic block(input int x0, input int y0, input int w, input int h);
    for (int j = 0; j < h; j++) begin
      for (int i = 0; i < w; i++) begin
        px(x0 + i, y0 + j, 1'b1, 1'b1);
        px(2000, 1000, 1'b1, 1'b0);
        px(2000, 1000, 1'b0, 1'b1);
      end
    end
  endtask

  // Ends in the cycle after the frame_done_in cycle (latency 1).
  task automatic end_frame();
    frame_done_in = 1'b1;
    tick();
    idle();
  endtask

  task automatic end_frame_px(input int x, input int y);
    frame_done_in  = 1'b1;
    pixel_valid_in = 1'b1;
    mask_in        = 1'b1;
    hcount_in      = 11'(x);
    vcount_in      = 10'(y);
    tick();
    idle();
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat = 1;
    while (valid_out !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic check_res(input string tag, input int x, input int y, input int a,
                           input logic f);
    check({tag, "_x"}, 32'(x_out), x);
    check({tag, "_y"}, 32'(y_out), y);
    check({tag, "_area"}, 32'(area_out), a);
    check({tag, "_found"}, 32'(found_out), 32'(f));
  endtask

  task automatic watch(input int n, output int v, output int d);
    v = 0;
    d = 0;
    for (int i = 0; i < n; i++) begin
      if (valid_out === 1'b1) v++;
      if (frame_drop_out === 1'b1) d++;
      tick();
    end
  endtask

  initial begin
    int nv, nd;
    rst_n_in = 1'b0;
    idle();
    repeat (3) tick();
    check_res("reset", 0, 0, 0, 1'b0);
    check("reset_valid", 32'(valid_out), 0);
    check("reset_drop", 32'(frame_drop_out), 0);
    rst_n_in = 1'b1;
    tick();

    // Partial first frame after reset is discarded.
    block(5, 5, 2, 2);
    end_frame();
    watch(40, nv, nd);
    check("partial_valid_count", nv, 0);
    check("partial_drop_count", nd, 0);

    // 4x4 block at 100..103 / 50..53.
    block(100, 50, 4, 4);
    end_frame();
    wait_valid("blk", 34);
    check_res("blk", 101, 51, 16, 1'b1);
`ifdef MASK_CENTROID_BBOX_EN
    check("blk_bx0", 32'(bbox_x0_out), 100);
    check("blk_by0", 32'(bbox_y0_out), 50);
    check("blk_bx1", 32'(bbox_x1_out), 103);
    check("blk_by1", 32'(bbox_y1_out), 53);
`endif
    tick();
    check("blk_valid_one_cycle", 32'(valid_out), 0);
    repeat (5) tick();
    check_res("blk_hold", 101, 51, 16, 1'b1);

    // Empty frame.
    end_frame();
    wait_valid("empty", 2);
    check_res("empty", 101, 51, 0, 1'b0);
    tick();

    // 15 vs 16 masked pixels around MIN_AREA.
    block(10, 5, 15, 1);
    end_frame();
    wait_valid("px15", 2);
    check_res("px15", 101, 51, 15, 1'b0);
    tick();
    block(10, 7, 16, 1);
    end_frame();
    wait_valid("px16", 34);
    check_res("px16", 17, 7, 16, 1'b1);
    tick();

    // Pixel coincident with frame_done_in belongs to the ending frame.
    block(300, 20, 15, 1);
    end_frame_px(200, 100);
    wait_valid("coinc", 34);
    check_res("coinc", 300, 25, 16, 1'b1);
    tick();
    end_frame();
    wait_valid("after_coinc", 2);
    check_res("after_coinc", 300, 25, 0, 1'b0);
    tick();

    // Second frame_done_in during DIV is dropped; in-flight result unaffected.
    block(20, 40, 4, 4);
    end_frame();
    for (int n = 1; n <= 36; n++) begin
      check($sformatf("drop_valid_c%0d", n), 32'(valid_out), 32'(n == 34));
      check($sformatf("drop_strobe_c%0d", n), 32'(frame_drop_out), 32'(n == 11));
      if (n == 34) check_res("drop_res", 21, 41, 16, 1'b1);
      frame_done_in  = (n == 10);
      pixel_valid_in = (n >= 3 && n <= 5) || (n >= 12 && n <= 14);
      mask_in        = pixel_valid_in;
      hcount_in      = (n < 10) ? 11'd500 : 11'd7;
      vcount_in      = (n < 10) ? 10'd300 : 10'd9;
      tick();
    end
    idle();
    end_frame();
    wait_valid("post_drop", 2);
    check_res("post_drop", 21, 41, 3, 1'b0);
    tick();

    // Reset in DIV cycle 15 aborts the division.
    block(60, 30, 4, 4);
    end_frame();
    repeat (14) tick();
    rst_n_in = 1'b0;
    #1;
    check_res("midreset", 0, 0, 0, 1'b0);
    check("midreset_valid", 32'(valid_out), 0);
    check("midreset_drop", 32'(frame_drop_out), 0);
    repeat (2) tick();
    rst_n_in = 1'b1;
    watch(5, nv, nd);
    check("postreset_valid_a", nv, 0);
    end_frame();
    watch(60, nv, nd);
    check("postreset_valid_b", nv, 0);
    check("postreset_drop", nd, 0);
    check_res("postreset", 0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
